// File: rtl/invg_loader.sv
// invg_loader: streams P centred coefficients of an Rq polynomial into the
// Invg coefficient store. Each accepted coefficient is range-checked and
// mapped to its canonical representative in [0, Q-1]. Out-of-range values
// are written as 0 and flagged with a sticky error. A one-cycle done pulse
// accompanies the final write.
module invg_loader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int P             = 757,
  parameter int Q             = 4591
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [RAM_WIDTH-1:0]     in_coef,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     input_data,
  output logic                     busy,
  output logic                     done,
  output logic                     range_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                     HALF_Q   = (Q - 1) / 2;
  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(P - 1);
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);
  localparam logic [RAM_WIDTH:0]     Q_EXT    = (RAM_WIDTH + 1)'(Q);

  // True when the centred coefficient lies within +-(Q-1)/2.
  function automatic logic coef_in_range(input logic [RAM_WIDTH-1:0] c);
    int v;
    v = int'($signed(c));
    coef_in_range = (v >= -HALF_Q) && (v <= HALF_Q);
  endfunction

  // Canonical representative: negative values wrap by +Q in one extra bit,
  // out-of-range values are replaced with 0.
  function automatic logic [RAM_WIDTH-1:0] to_canonical(input logic [RAM_WIDTH-1:0] c);
    logic [RAM_WIDTH:0] ext;
    logic [RAM_WIDTH:0] sum;
    ext = {c[RAM_WIDTH-1], c};
    if (!coef_in_range(c)) begin
      sum = {(RAM_WIDTH + 1){1'b0}};
    end else if (c[RAM_WIDTH-1]) begin
      sum = ext + Q_EXT;
    end else begin
      sum = ext;
    end
    to_canonical = sum[RAM_WIDTH-1:0];
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_in_ready;
  logic                     w_busy;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_start_load;

  logic [RAM_ADDR_BITS-1:0] r_cnt;
  logic                     r_we;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [RAM_WIDTH-1:0]     r_data;
  logic                     r_err;
  logic                     r_done;

  assign w_accept     = in_valid & w_in_ready;
  assign w_last       = w_accept & (r_cnt == LAST_IDX);
  assign w_start_load = (r_state == S_IDLE) & start;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write port, coefficient counter, sticky range error and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {RAM_ADDR_BITS{1'b0}};
      r_we   <= 1'b0;
      r_addr <= {RAM_ADDR_BITS{1'b0}};
      r_data <= {RAM_WIDTH{1'b0}};
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_load) begin
        r_cnt <= {RAM_ADDR_BITS{1'b0}};
        r_err <= 1'b0;
        r_we  <= 1'b0;
      end else if (w_accept) begin
        r_we   <= 1'b1;
        r_addr <= r_cnt;
        r_data <= to_canonical(in_coef);
        r_cnt  <= r_cnt + ADDR_ONE;
        if (!coef_in_range(in_coef)) begin
          r_err <= 1'b1;
        end else begin
          r_err <= r_err;
        end
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign busy          = w_busy;
  assign write_enable  = r_we;
  assign write_address = r_addr;
  assign input_data    = r_data;
  assign range_err     = r_err;
  assign done          = r_done;

endmodule

// File: tb/tb_invg_loader.sv
// Testbench for invg_loader: randomized coefficient loads compared against
// a plain-arithmetic reference of the canonical mapping and load timing.
module tb_invg_loader;

  localparam int P  = 757;
  localparam int Q  = 4591;
  localparam int W  = 13;
  localparam int AW = 11;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_coef  = 13'd0;
  logic          in_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [W-1:0]  input_data;
  logic          busy;
  logic          done;
  logic          range_err;

  invg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_coef      (in_coef),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_address(write_address),
    .input_data   (input_data),
    .busy         (busy),
    .done         (done),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  int coefs[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int first_err_idx;
  int err_drop;
  int done_cnt;
  int done_cyc;
  int done_addr;
  int done_we;

  // Reference: canonical representative in [0, Q-1], 0 when out of range.
  function automatic int model(input int c);
    if (c < -(Q - 1) / 2 || c > (Q - 1) / 2) return 0;
    return (c < 0) ? c + Q : c;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Store-side monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (write_enable) begin
      wr_addr_q.push_back(int'(write_address));
      wr_data_q.push_back(int'(input_data));
      wr_cyc_q.push_back(cyc);
      if (range_err && first_err_idx < 0) first_err_idx = wr_addr_q.size() - 1;
      if (!range_err && first_err_idx >= 0) err_drop++;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_addr = int'(write_address);
      done_we   = int'(write_enable);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    first_err_idx = -1;
    err_drop      = 0;
    done_cnt      = 0;
    done_cyc      = -1;
    done_addr     = -1;
    done_we       = -1;
  endtask

  // Drives start then the coefficient queue; stops after n_stop acceptances.
  task automatic run_load(input bit toggle, input bit extra, input int n_stop);
    int  k = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    clear_log();
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_entry: in_ready %0b busy %0b, expected 1 1", in_ready, busy);
    end
    while (k < n_stop && guard < 5000) begin
      if (toggle && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_coef  = 13'(coefs[k]);
      end
      start = (extra && (k == 100 || k == 200)) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      if (in_valid) k++;
      ph = ~ph;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    n_checks++;
    if (k != n_stop) begin
      n_fail++;
      $display("FAIL load_budget: accepted %0d, expected %0d", k, n_stop);
    end
    if (n_stop == coefs.size()) begin
      n_checks++;
      if (done !== 1'b1 || in_ready !== 1'b0 || write_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL done_cycle: done %0b in_ready %0b we %0b, expected 1 0 1", done, in_ready, write_enable);
      end
      if (extra) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({write_enable, write_address, input_data, busy, done, range_err, in_ready} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {write_enable, write_address, input_data, busy, done, range_err, in_ready});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({write_enable, write_address, input_data, busy, done, range_err, in_ready} !== 29'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, expected 0",
               {write_enable, write_address, input_data, busy, done, range_err, in_ready});
    end
  endtask

  task automatic test_ramp();
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(k - 378);
    run_load(1'b0, 1'b0, P);
    n_checks++;
    if (wr_addr_q.size() != P) begin
      n_fail++;
      $display("FAIL ramp_count: got %0d writes, expected %0d", wr_addr_q.size(), P);
    end
    for (int i = 0; i < wr_addr_q.size() && i < P; i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != model(coefs[i]) || wr_cyc_q[i] != start_cyc + 1 + i) begin
        n_fail++;
        $display("FAIL ramp_write[%0d]: got addr %0d data %0d cyc %0d, expected addr %0d data %0d cyc %0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, model(coefs[i]), start_cyc + 1 + i);
      end
    end
    n_checks++;
    if (wr_data_q.size() == P && (wr_data_q[0] != 4213 || wr_data_q[378] != 0)) begin
      n_fail++;
      $display("FAIL ramp_anchor: got %0d %0d, expected 4213 0", wr_data_q[0], wr_data_q[378]);
    end
    n_checks++;
    if (done_cnt != 1 || done_addr != P - 1 || done_we != 1 || done_cyc - start_cyc != P) begin
      n_fail++;
      $display("FAIL ramp_done: cnt %0d addr %0d we %0d lat %0d, expected 1 %0d 1 %0d",
               done_cnt, done_addr, done_we, done_cyc - start_cyc, P - 1, P);
    end
    n_checks++;
    if (range_err !== 1'b0 || first_err_idx != -1) begin
      n_fail++;
      $display("FAIL ramp_err: range_err %0b first %0d, expected 0 -1", range_err, first_err_idx);
    end
  endtask

  task automatic test_boundary_oor();
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(int'($urandom_range(0, 4590)) - 2295);
    coefs[0] = 2295;
    coefs[1] = -2295;
    coefs[2] = -1;
    coefs[3] = 0;
    coefs[4] = 17;
    coefs[5] = 2296;
    coefs[9] = -4096;
    run_load(1'b0, 1'b0, P);
    n_checks++;
    if (wr_addr_q.size() != P) begin
      n_fail++;
      $display("FAIL bound_count: got %0d writes, expected %0d", wr_addr_q.size(), P);
    end
    for (int i = 0; i < wr_addr_q.size() && i < P; i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != model(coefs[i])) begin
        n_fail++;
        $display("FAIL bound_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, model(coefs[i]));
      end
    end
    n_checks++;
    if (wr_data_q.size() == P &&
        (wr_data_q[0] != 2295 || wr_data_q[1] != 2296 || wr_data_q[2] != 4590 ||
         wr_data_q[3] != 0 || wr_data_q[5] != 0 || wr_data_q[9] != 0)) begin
      n_fail++;
      $display("FAIL bound_values: got %0d %0d %0d %0d %0d %0d, expected 2295 2296 4590 0 0 0",
               wr_data_q[0], wr_data_q[1], wr_data_q[2], wr_data_q[3], wr_data_q[5], wr_data_q[9]);
    end
    n_checks++;
    if (first_err_idx != 5 || err_drop != 0 || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bound_err: first %0d drops %0d final %0b, expected 5 0 1",
               first_err_idx, err_drop, range_err);
    end
  endtask

  task automatic test_extra_start();
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(int'($urandom_range(0, 4590)) - 2295);
    run_load(1'b0, 1'b1, P);
    n_checks++;
    if (wr_addr_q.size() != P) begin
      n_fail++;
      $display("FAIL extra_count: got %0d writes, expected %0d", wr_addr_q.size(), P);
    end
    for (int i = 0; i < wr_addr_q.size() && i < P; i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != model(coefs[i])) begin
        n_fail++;
        $display("FAIL extra_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, model(coefs[i]));
      end
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done_cnt != 1 || done_cyc - start_cyc != P) begin
      n_fail++;
      $display("FAIL extra_fsm: busy %0b ready %0b dones %0d lat %0d, expected 0 0 1 %0d",
               busy, in_ready, done_cnt, done_cyc - start_cyc, P);
    end
    n_checks++;
    if (range_err !== 1'b0 || first_err_idx != -1) begin
      n_fail++;
      $display("FAIL extra_err_clear: range_err %0b first %0d, expected 0 -1", range_err, first_err_idx);
    end
  endtask

  task automatic test_toggle();
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(int'($urandom_range(0, 8191)) - 4096);
    run_load(1'b1, 1'b0, P);
    n_checks++;
    if (wr_addr_q.size() != P) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d writes, expected %0d", wr_addr_q.size(), P);
    end
    for (int i = 0; i < wr_addr_q.size() && i < P; i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != model(coefs[i]) || wr_cyc_q[i] != start_cyc + 1 + 2 * i) begin
        n_fail++;
        $display("FAIL toggle_write[%0d]: got addr %0d data %0d cyc %0d, expected addr %0d data %0d cyc %0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, model(coefs[i]), start_cyc + 1 + 2 * i);
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 2 * P - 1) begin
      n_fail++;
      $display("FAIL toggle_done: dones %0d lat %0d, expected 1 %0d", done_cnt, done_cyc - start_cyc, 2 * P - 1);
    end
  endtask

  task automatic test_midload_reset();
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(int'($urandom_range(0, 4590)) - 2295);
    coefs[5] = 3000;
    run_load(1'b0, 1'b0, 300);
    n_checks++;
    if (wr_addr_q.size() != 299 || write_enable !== 1'b1 || int'(write_address) != 299 || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_state: writes %0d we %0b addr %0d err %0b, expected 299 1 299 1",
               wr_addr_q.size(), write_enable, write_address, range_err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({write_enable, write_address, input_data, busy, done, range_err, in_ready} !== 29'd0) begin
      n_fail++;
      $display("FAIL midload_reset: got %h, expected 0",
               {write_enable, write_address, input_data, busy, done, range_err, in_ready});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    coefs.delete();
    for (int k = 0; k < P; k++) coefs.push_back(int'($urandom_range(0, 4590)) - 2295);
    run_load(1'b0, 1'b0, P);
    n_checks++;
    if (wr_addr_q.size() != P) begin
      n_fail++;
      $display("FAIL reload_count: got %0d writes, expected %0d", wr_addr_q.size(), P);
    end
    for (int i = 0; i < wr_addr_q.size() && i < P; i++) begin
      n_checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != model(coefs[i])) begin
        n_fail++;
        $display("FAIL reload_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, model(coefs[i]));
      end
    end
    n_checks++;
    if (range_err !== 1'b0 || first_err_idx != -1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL reload_err: range_err %0b first %0d dones %0d, expected 0 -1 1",
               range_err, first_err_idx, done_cnt);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_ramp();
    test_boundary_oor();
    test_extra_start();
    test_toggle();
    test_midload_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
